// File: rtl/count_mod.sv
// count_mod: modulo-MOD up/down event counter with synchronous load,
// combinational terminal count for cascading, sticky wrap flag and a
// one-cycle out-of-range load indication.
module count_mod #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_wrap,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ld_err
);

  // Largest value in the count sequence; fits in WIDTH bits even when MOD = 2**WIDTH.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  // Reject a modulus that cannot be represented or would give a degenerate counter.
  if (MOD < 2 || MOD > 2 ** WIDTH) begin : g_bad_mod
    $fatal(1, "count_mod: MOD=%0d illegal for WIDTH=%0d", MOD, WIDTH);
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ld_err_q, ld_err_d;
  logic             at_term;

  // Terminal count: the current edge would wrap in the selected direction.
  always_comb begin
    at_term = up ? (count_q == MAX_VAL) : (count_q == '0);
    tc      = en & ~ld & ~rst & at_term;
  end

  // Next-state: load beats count; a load never wraps, so tc alone marks a wrap edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    count_d  = count_q;
    wrap_d   = wrap_q;
    ld_err_d = 1'b0;

    if (ld) begin
      if (din > MAX_VAL) begin
        count_d  = MAX_VAL;
        ld_err_d = 1'b1;
      end else begin
        count_d  = din;
      end
    end else if (en) begin
      if (up) begin
        count_d = at_term ? '0 : count_q + ONE;
      end else begin
        count_d = at_term ? MAX_VAL : count_q - ONE;
      end
    end

    // Setting the flag takes precedence over clearing it on the same edge.
    if (tc) begin
      wrap_d = 1'b1;
    end else if (clr_wrap) begin
      wrap_d = 1'b0;
    end
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge ck) begin
    // NOTE: non-blocking assignments so all registers update together from pre-edge values.
    if (rst) begin
      count_q  <= '0;
      wrap_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign q      = count_q;
  assign wrap   = wrap_q;
  assign ld_err = ld_err_q;

endmodule

// File: tb/tb_count_mod.sv
// tb_count_mod: two cascaded count_mod stages (WIDTH=4, MOD=10) checked
// against an integer reference model, directed steps then random traffic.
module tb_count_mod;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic             ck;
  logic             rst, en, up, ld, clr_wrap;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q_a, q_b;
  logic             tc_a, tc_b, wrap_a, wrap_b, ld_err_a, ld_err_b;

  count_mod #(.WIDTH(WIDTH), .MOD(MOD)) u_a (
    .ck(ck), .rst(rst), .en(en), .up(up), .ld(ld), .din(din),
    .clr_wrap(clr_wrap), .q(q_a), .tc(tc_a), .wrap(wrap_a), .ld_err(ld_err_a)
  );

  // Second digit stage: enabled by the first stage's carry, always counting up.
  count_mod #(.WIDTH(WIDTH), .MOD(MOD)) u_b (
    .ck(ck), .rst(rst), .en(tc_a), .up(1'b1), .ld(1'b0), .din('0),
    .clr_wrap(1'b0), .q(q_b), .tc(tc_b), .wrap(wrap_b), .ld_err(ld_err_b)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state: plain integers in 0..MOD-1.
  int ma = 0, mb = 0;
  bit wa = 0, wb = 0, lea = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive inputs, check tc before the edge, advance model, check state after.
  task automatic step(bit r, bit e, bit u, bit l, logic [WIDTH-1:0] d, bit c);
    int  raw;
    bit  a_wraps, b_wraps;
    rst = r; en = e; up = u; ld = l; din = d; clr_wrap = c;
    #2;
    raw     = u ? ma + 1 : ma - 1;
    a_wraps = !r && !l && e && (raw < 0 || raw >= MOD);
    b_wraps = a_wraps && (mb + 1 >= MOD);
    check("tc_a", 32'(tc_a), 32'(a_wraps));
    check("tc_b", 32'(tc_b), 32'(b_wraps));
    @(posedge ck);
    #1;
    cyc++;
    if (r) begin
      ma = 0; mb = 0; wa = 0; wb = 0; lea = 0;
    end else begin
      lea = 0;
      if (l) begin
        if (int'(d) < MOD) ma = int'(d);
        else begin
          ma  = MOD - 1;
          lea = 1;
        end
      end else if (e) begin
        ma = (raw + MOD) % MOD;
      end
      if (a_wraps) wa = 1;
      else if (c)  wa = 0;
      if (a_wraps) mb = (mb + 1) % MOD;
      if (b_wraps) wb = 1;
    end
    check("q_a",      32'(q_a),      32'(ma));
    check("wrap_a",   32'(wrap_a),   32'(wa));
    check("ld_err_a", 32'(ld_err_a), 32'(lea));
    check("q_b",      32'(q_b),      32'(mb));
    check("wrap_b",   32'(wrap_b),   32'(wb));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; ld = 1'b0; din = '0; clr_wrap = 1'b0;

    // Reset state.
    step(1, 0, 1, 0, 4'd0, 0);
    check("rst_q",      32'(q_a),      32'd0);
    check("rst_wrap",   32'(wrap_a),   32'd0);
    check("rst_ld_err", 32'(ld_err_a), 32'd0);

    // Up-count through a wrap: 0..9,0,1,2.
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 4'd0, 0);
    check("up_end_q",    32'(q_a),    32'd2);
    check("up_end_wrap", 32'(wrap_a), 32'd1);

    // Down-count wrap from a loaded 2: 2,1,0,9,8.
    step(0, 0, 1, 1, 4'd2, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 4'd0, 0);
    check("down_end_q", 32'(q_a), 32'd8);

    // Load wins over count; in-range then out-of-range load.
    step(0, 1, 1, 1, 4'd7, 0);
    check("ld7_q",      32'(q_a),      32'd7);
    check("ld7_ld_err", 32'(ld_err_a), 32'd0);
    step(0, 0, 1, 1, 4'd12, 0);
    check("ld12_q",      32'(q_a),      32'd9);
    check("ld12_ld_err", 32'(ld_err_a), 32'd1);
    step(0, 0, 1, 0, 4'd0, 0);
    check("ld_err_pulse", 32'(ld_err_a), 32'd0);

    // Sticky flag: clear, then wrap racing clr_wrap, then a plain clear.
    step(0, 0, 1, 0, 4'd0, 1);
    check("clr_wrap", 32'(wrap_a), 32'd0);
    step(0, 1, 1, 0, 4'd0, 1);
    check("race_wrap", 32'(wrap_a), 32'd1);
    step(0, 0, 1, 0, 4'd0, 1);
    check("race_clear", 32'(wrap_a), 32'd0);

    // Enable gating from 3: en 1,0,0,1 gives 4,4,4,5.
    step(0, 0, 1, 1, 4'd3, 0);
    step(0, 1, 1, 0, 4'd0, 0);
    step(0, 0, 1, 0, 4'd0, 0);
    step(0, 0, 1, 0, 4'd0, 0);
    step(0, 1, 1, 0, 4'd0, 0);
    check("gate_q", 32'(q_a), 32'd5);

    // Cascade: 25 counts from reset reads 2|5; then reset mid-run.
    step(1, 0, 1, 0, 4'd0, 0);
    for (int i = 0; i < 25; i++) step(0, 1, 1, 0, 4'd0, 0);
    check("casc_lo", 32'(q_a), 32'd5);
    check("casc_hi", 32'(q_b), 32'd2);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 4'd0, 0);
    step(1, 1, 1, 1, 4'd6, 0);
    check("mid_rst_lo", 32'(q_a), 32'd0);
    check("mid_rst_hi", 32'(q_b), 32'd0);

    // Random traffic: rare resets, occasional loads (including out-of-range values).
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 7) == 0,
           WIDTH'($urandom_range(0, 15)),
           $urandom_range(0, 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
